// File: rtl/uart_fifo.sv
// uart_fifo: UART with a runtime baud divisor, TX/RX FIFOs and error flags.
// Build option: define UART_PARITY_EN to add a parity bit to every frame.
module uart_fifo #(
  parameter int NB_DATA  = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR_BIT = 11,
  parameter int FIFO_W   = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DVSR_BIT-1:0] i_dvsr,
  input  logic                i_wr,
  input  logic [NB_DATA-1:0]  i_wr_data,
  output logic                o_tx_full,
  input  logic                i_rd,
  output logic [NB_DATA-1:0]  o_rd_data,
  output logic                o_rx_empty,
  output logic                o_rx_overrun,
  output logic                o_frame_err,
  output logic                o_parity_err,
  input  logic                i_parity_odd,
  input  logic                i_rx,
  output logic                o_tx
);

  localparam int DEPTH = 1 << FIFO_W;
  localparam int S_W   = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W   = $clog2(NB_DATA + 1);
  localparam logic [FIFO_W:0] FULL_CNT = {1'b1, {FIFO_W{1'b0}}};

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // ---------------- baud tick ----------------
  logic [DVSR_BIT-1:0] baud_cnt;
  logic                tick;

  assign tick = (baud_cnt >= i_dvsr);

  // Free-running divisor counter; wraps on every tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + 1'b1;
  end

  // ---------------- rx synchroniser ----------------
  logic rx_meta, rx_sync;

  // Two-flop synchroniser; idles high like the line itself.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- tx fifo ----------------
  logic [NB_DATA-1:0] tx_mem [DEPTH];
  logic [FIFO_W-1:0]  tx_wptr, tx_rptr;
  logic [FIFO_W:0]    tx_count, tx_count_n;
  logic               tx_full, tx_empty, tx_pop, tx_do_push, tx_do_pop;
  logic [NB_DATA-1:0] tx_head;

  assign tx_head   = tx_mem[tx_rptr];
  assign o_tx_full = tx_full;

  // Accept push/pop only when legal; the count drives the registered flags.
  always_comb begin
    tx_do_push = i_wr && !tx_full;
    tx_do_pop  = tx_pop && !tx_empty;
    tx_count_n = tx_count + (FIFO_W+1)'(tx_do_push) - (FIFO_W+1)'(tx_do_pop);
  end

  // TX storage needs no reset; stale words are never read.
  always_ff @(posedge i_clk) begin
    if (tx_do_push) tx_mem[tx_wptr] <= i_wr_data;
  end

  // TX pointers, count and flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      tx_full  <= 1'b0;
      tx_empty <= 1'b1;
    end else begin
      if (tx_do_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_do_pop)  tx_rptr <= tx_rptr + 1'b1;
      tx_count <= tx_count_n;
      tx_full  <= (tx_count_n == FULL_CNT);
      tx_empty <= (tx_count_n == '0);
    end
  end

  // ---------------- tx fsm ----------------
  state_t             tx_state, tx_state_n;
  logic [S_W-1:0]     tx_s, tx_s_n;
  logic [N_W-1:0]     tx_n, tx_n_n;
  logic [NB_DATA-1:0] tx_b, tx_b_n;
  logic               tx_reg, tx_reg_n;
`ifdef UART_PARITY_EN
  logic               tx_par, tx_par_n;
`endif

  // TX state registers; the line output is registered so reset forces it high at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state <= ST_IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      tx_reg   <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_s     <= tx_s_n;
      tx_n     <= tx_n_n;
      tx_b     <= tx_b_n;
      tx_reg   <= tx_reg_n;
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // TX next state; a frame is loaded from the FIFO in IDLE or straight from STOP.
  always_comb begin
    tx_state_n = tx_state;
    tx_s_n     = tx_s;
    tx_n_n     = tx_n;
    tx_b_n     = tx_b;
    tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_b_n     = tx_head;
          tx_s_n     = '0;
          tx_state_n = ST_START;
`ifdef UART_PARITY_EN
          tx_par_n   = (^tx_head) ^ i_parity_odd;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          if (tx_s == S_W'(15)) begin
            tx_s_n     = '0;
            tx_n_n     = '0;
            tx_state_n = ST_DATA;
          end else tx_s_n = tx_s + 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tx_s == S_W'(15)) begin
            tx_s_n = '0;
            tx_b_n = tx_b >> 1;
            if (tx_n == N_W'(NB_DATA - 1)) begin
`ifdef UART_PARITY_EN
              tx_state_n = ST_PARITY;
`else
              tx_state_n = ST_STOP;
`endif
            end else tx_n_n = tx_n + 1'b1;
          end else tx_s_n = tx_s + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (tx_s == S_W'(15)) begin
            tx_s_n     = '0;
            tx_state_n = ST_STOP;
          end else tx_s_n = tx_s + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (tx_s == S_W'(SB_TICK - 1)) begin
            tx_s_n = '0;
            if (!tx_empty) begin
              tx_pop     = 1'b1;
              tx_b_n     = tx_head;
              tx_state_n = ST_START;
`ifdef UART_PARITY_EN
              tx_par_n   = (^tx_head) ^ i_parity_odd;
`endif
            end else tx_state_n = ST_IDLE;
          end else tx_s_n = tx_s + 1'b1;
        end
      end
      default: tx_state_n = ST_IDLE;
    endcase
    case (tx_state_n)
      ST_START: tx_reg_n = 1'b0;
      ST_DATA:  tx_reg_n = tx_b_n[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_reg_n = tx_par_n;
`endif
      default:  tx_reg_n = 1'b1;
    endcase
  end

  assign o_tx = tx_reg;

  // ---------------- rx fsm ----------------
  state_t             rx_state, rx_state_n;
  logic [S_W-1:0]     rx_s, rx_s_n;
  logic [N_W-1:0]     rx_n, rx_n_n;
  logic [NB_DATA-1:0] rx_b, rx_b_n;
  logic               rx_push, frame_err_n, frame_err_q;
`ifdef UART_PARITY_EN
  logic               rx_par, rx_par_n, parity_err_n, parity_err_q;
`else
  logic               unused_parity;
  assign unused_parity = i_parity_odd;
`endif

  // RX state registers plus the one-cycle error pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state     <= ST_IDLE;
      rx_s         <= '0;
      rx_n         <= '0;
      rx_b         <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_state     <= rx_state_n;
      rx_s         <= rx_s_n;
      rx_n         <= rx_n_n;
      rx_b         <= rx_b_n;
      frame_err_q  <= frame_err_n;
`ifdef UART_PARITY_EN
      rx_par       <= rx_par_n;
      parity_err_q <= parity_err_n;
`endif
    end
  end

  // RX next state; samples mid-bit, framing error outranks parity error.
  always_comb begin
    rx_state_n  = rx_state;
    rx_s_n      = rx_s;
    rx_n_n      = rx_n;
    rx_b_n      = rx_b;
    rx_push     = 1'b0;
    frame_err_n = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_n     = rx_par;
    parity_err_n = 1'b0;
`endif
    case (rx_state)
      ST_IDLE: begin
        if (!rx_sync) begin
          rx_s_n     = '0;
          rx_state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rx_s == S_W'(7)) begin
            rx_s_n = '0;
            rx_n_n = '0;
            rx_state_n = rx_sync ? ST_IDLE : ST_DATA;
          end else rx_s_n = rx_s + 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (rx_s == S_W'(15)) begin
            rx_s_n = '0;
            rx_b_n = {rx_sync, rx_b[NB_DATA-1:1]};
            if (rx_n == N_W'(NB_DATA - 1)) begin
`ifdef UART_PARITY_EN
              rx_state_n = ST_PARITY;
`else
              rx_state_n = ST_STOP;
`endif
            end else rx_n_n = rx_n + 1'b1;
          end else rx_s_n = rx_s + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (rx_s == S_W'(15)) begin
            rx_s_n     = '0;
            rx_par_n   = rx_sync;
            rx_state_n = ST_STOP;
          end else rx_s_n = rx_s + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (rx_s == S_W'(SB_TICK - 1)) begin
            rx_s_n     = '0;
            rx_state_n = ST_IDLE;
            if (!rx_sync) frame_err_n = 1'b1;
`ifdef UART_PARITY_EN
            else if (((^rx_b) ^ i_parity_odd) != rx_par) parity_err_n = 1'b1;
`endif
            else rx_push = 1'b1;
          end else rx_s_n = rx_s + 1'b1;
        end
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

  assign o_frame_err = frame_err_q;
`ifdef UART_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

  // ---------------- rx fifo ----------------
  logic [NB_DATA-1:0] rx_mem [DEPTH];
  logic [FIFO_W-1:0]  rx_wptr, rx_rptr;
  logic [FIFO_W:0]    rx_count, rx_count_n;
  logic               rx_full, rx_empty, rx_do_push, rx_do_pop, overrun;

  assign o_rd_data    = rx_mem[rx_rptr];
  assign o_rx_empty   = rx_empty;
  assign o_rx_overrun = overrun;

  // Legal RX push/pop and the resulting occupancy.
  always_comb begin
    rx_do_push = rx_push && !rx_full;
    rx_do_pop  = i_rd && !rx_empty;
    rx_count_n = rx_count + (FIFO_W+1)'(rx_do_push) - (FIFO_W+1)'(rx_do_pop);
  end

  // RX storage is reset so the fall-through head reads 0 out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
    end else if (rx_do_push) begin
      rx_mem[rx_wptr] <= rx_b;
    end
  end

  // RX pointers, flags and the sticky overrun (a drop wins over a same-cycle read).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
      rx_full  <= 1'b0;
      rx_empty <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      if (rx_do_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_do_pop)  rx_rptr <= rx_rptr + 1'b1;
      rx_count <= rx_count_n;
      rx_full  <= (rx_count_n == FULL_CNT);
      rx_empty <= (rx_count_n == '0);
      if (rx_push && rx_full) overrun <= 1'b1;
      else if (rx_do_pop)     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: self-checking bench for uart_fifo with a 64-clock bit time.
module tb_uart_fifo;

  localparam int NB_DATA  = 8;
  localparam int DEPTH    = 4;
  localparam int DVSR     = 3;
  localparam int BIT_CLKS = 16 * (DVSR + 1);
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] dvsr;
  logic        wr;
  logic [7:0]  wr_data;
  logic        tx_full;
  logic        rd;
  logic [7:0]  rd_data;
  logic        rx_empty, rx_overrun, frame_err, parity_err;
  logic        parity_odd;
  logic        rx_line, tx_line;
  logic        loopback, rx_drive;

  assign rx_line = loopback ? tx_line : rx_drive;

  always #5 clk = ~clk;

  uart_fifo dut (
    .i_clk(clk), .i_rst(rst), .i_dvsr(dvsr),
    .i_wr(wr), .i_wr_data(wr_data), .o_tx_full(tx_full),
    .i_rd(rd), .o_rd_data(rd_data), .o_rx_empty(rx_empty),
    .o_rx_overrun(rx_overrun), .o_frame_err(frame_err), .o_parity_err(parity_err),
    .i_parity_odd(parity_odd), .i_rx(rx_line), .o_tx(tx_line)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;

  logic [7:0] exp_q[$];
  logic       tx_bits_q[$];

  typedef struct {
    logic [7:0] data;
    int         glitch_clks;
    logic       stop_bit;
    logic       par_flip;
    logic       odd;
    logic       exp_push;
    int         exp_ferr;
    int         exp_perr;
  } rx_vec_t;

  rx_vec_t vecs [8];
  int      n_vec;

  // Count high cycles of the error pulses so width and occurrence are both checked.
  always @(posedge clk) begin
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (parity_err) perr_cnt <= perr_cnt + 1;
  end

  // Absolute time limit in case the design stalls a wait.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic writeByte(input logic [7:0] d);
    int guard = 0;
    while (tx_full && guard < 4 * FRAME_CLKS) begin
      step(1);
      guard++;
    end
    if (tx_full) begin
      checkOutput("tx_full wait", tx_full, 0);
      return;
    end
    wr = 1'b1;
    wr_data = d;
    step(1);
    wr = 1'b0;
  endtask

  task automatic readAll(input string name);
    for (int k = 0; k < DEPTH + 2; k++) begin
      checkOutput({name, " rx_empty"}, rx_empty, (exp_q.size() == 0));
      if (rx_empty) break;
      if (exp_q.size() != 0) checkOutput({name, " rd_data"}, rd_data, exp_q.pop_front());
      rd = 1'b1;
      step(1);
      rd = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic applyStimulus(input rx_vec_t v, input string name);
    int f0 = ferr_cnt;
    int p0 = perr_cnt;
    parity_odd = v.odd;
    if (v.glitch_clks != 0) begin
      rx_drive = 1'b0;
      step(v.glitch_clks);
    end else begin
      rx_drive = 1'b0;
      step(BIT_CLKS);
      for (int b = 0; b < NB_DATA; b++) begin
        rx_drive = v.data[b];
        step(BIT_CLKS);
      end
`ifdef UART_PARITY_EN
      rx_drive = (^v.data) ^ v.odd ^ v.par_flip;
      step(BIT_CLKS);
`endif
      if (v.stop_bit) begin
        rx_drive = 1'b1;
        step(BIT_CLKS);
      end else begin
        rx_drive = 1'b0;
        step(48);
        rx_drive = 1'b1;
        step(BIT_CLKS - 48);
      end
    end
    rx_drive = 1'b1;
    step(2 * BIT_CLKS);
    if (v.exp_push) exp_q.push_back(v.data);
    checkOutput({name, " frame_err cycles"}, ferr_cnt - f0, v.exp_ferr);
    checkOutput({name, " parity_err cycles"}, perr_cnt - p0, v.exp_perr);
    readAll(name);
  endtask

  initial begin
    int lows;
    int f0;
    int model_cnt;

    // Directly driven RX frames: glitch, good frames, bad stop bits, parity cases.
    vecs[0] = '{8'h00, 16, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[1] = '{8'h55, 0,  1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[2] = '{8'h55, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
    vecs[3] = '{8'hA3, 0,  1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[4] = '{8'h00, 0,  1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
    n_vec = 5;
`ifdef UART_PARITY_EN
    vecs[5] = '{8'h07, 0,  1'b1, 1'b1, 1'b1, 1'b0, 0, 1};
    vecs[6] = '{8'h07, 0,  1'b1, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[7] = '{8'h55, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
    n_vec = 8;
`endif

    rst = 1'b1; dvsr = 11'(DVSR); wr = 1'b0; wr_data = '0; rd = 1'b0;
    parity_odd = 1'b0; loopback = 1'b0; rx_drive = 1'b1;
    step(3);
    checkOutput("reset o_tx", tx_line, 1);
    checkOutput("reset o_tx_full", tx_full, 0);
    checkOutput("reset o_rx_empty", rx_empty, 1);
    checkOutput("reset o_rd_data", rd_data, 0);
    checkOutput("reset o_rx_overrun", rx_overrun, 0);
    checkOutput("reset o_frame_err", frame_err, 0);
    checkOutput("reset o_parity_err", parity_err, 0);
    rst = 1'b0;
    step(2);

    // Serial shape of 0xA5: start, LSB-first data, optional parity, stop.
    $display("[TB] tx frame 0xA5");
    tx_bits_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) begin
      logic [7:0] a5 = 8'hA5;
      tx_bits_q.push_back(a5[b]);
    end
`ifdef UART_PARITY_EN
    tx_bits_q.push_back(1'b0);
`endif
    tx_bits_q.push_back(1'b1);
    wr = 1'b1; wr_data = 8'hA5;
    step(1);
    wr = 1'b0;
    checkOutput("tx high 1 clk after wr", tx_line, 1);
    step(1);
    checkOutput("tx low 2 clks after wr", tx_line, 0);
    step(31);
    for (int j = 0; j < FRAME_BITS; j++) begin
      checkOutput($sformatf("tx bit %0d", j), tx_line, tx_bits_q.pop_front());
      step(BIT_CLKS);
    end
    checkOutput("tx idle after frame", tx_line, 1);

    // Driven RX vectors.
    $display("[TB] rx vectors");
    for (int i = 0; i < n_vec; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));
    parity_odd = 1'b0;

    // Loopback: five frames into a four-deep RX FIFO with no reads.
    $display("[TB] loopback overrun");
    loopback = 1'b1;
    f0 = ferr_cnt;
    model_cnt = 0;
    foreach (vecs[i]) begin end
    for (int i = 0; i < 5; i++) begin
      logic [7:0] d;
      case (i)
        0: d = 8'h00;
        1: d = 8'hFF;
        2: d = 8'h3C;
        3: d = 8'hC3;
        default: d = 8'h81;
      endcase
      if (model_cnt < DEPTH) begin
        exp_q.push_back(d);
        model_cnt++;
      end
      writeByte(d);
    end
    step(5 * FRAME_CLKS + 400);
    checkOutput("loopback frame_err cycles", ferr_cnt - f0, 0);
    checkOutput("overrun before read", rx_overrun, 1);
    checkOutput("rx_empty with data", rx_empty, (exp_q.size() == 0));
    if (exp_q.size() != 0) checkOutput("first loopback word", rd_data, exp_q.pop_front());
    rd = 1'b1;
    step(1);
    rd = 1'b0;
    checkOutput("overrun after first read", rx_overrun, 0);
    readAll("loopback");
    loopback = 1'b0;
    step(4);

    // Reset in the middle of a frame with the TX FIFO full.
    $display("[TB] reset mid-frame");
    for (int i = 0; i < 5; i++) writeByte(8'h00);
    checkOutput("tx_full after fill", tx_full, 1);
    step(BIT_CLKS + 32);
    checkOutput("tx low mid data", tx_line, 0);
    #3 rst = 1'b1;
    #1;
    checkOutput("tx high on async reset", tx_line, 1);
    checkOutput("tx_full cleared by reset", tx_full, 0);
    checkOutput("rx_empty during reset", rx_empty, 1);
    step(3);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      if (!tx_line) lows++;
      step(1);
    end
    checkOutput("tx quiet after reset", lows, 0);
    checkOutput("tx_full after reset", tx_full, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
